// File: rtl/xrv_dbus_arb_if.sv
// Bundle of both master ports and the shared slave port of the data-bus arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface xrv_dbus_arb_if;
    logic [31:0] m0_addr;
    logic        m0_wr_req;
    logic [3:0]  m0_be;
    logic [31:0] m0_wr_data;
    logic        m0_wr_ready;
    logic        m0_rd_req;
    logic        m0_rd_ready;
    logic [31:0] m0_rd_data;
    logic        m0_err;

    logic [31:0] m1_addr;
    logic        m1_wr_req;
    logic [3:0]  m1_be;
    logic [31:0] m1_wr_data;
    logic        m1_wr_ready;
    logic        m1_rd_req;
    logic        m1_rd_ready;
    logic [31:0] m1_rd_data;
    logic        m1_err;

    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wr_data;
    logic        s_wr_req;
    logic        s_rd_req;
    logic        s_wr_ready;
    logic        s_rd_ready;
    logic [31:0] s_rd_data;

    modport slave (
        input  m0_addr, m0_wr_req, m0_be, m0_wr_data, m0_rd_req,
        output m0_wr_ready, m0_rd_ready, m0_rd_data, m0_err,
        input  m1_addr, m1_wr_req, m1_be, m1_wr_data, m1_rd_req,
        output m1_wr_ready, m1_rd_ready, m1_rd_data, m1_err,
        output s_addr, s_be, s_wr_data, s_wr_req, s_rd_req,
        input  s_wr_ready, s_rd_ready, s_rd_data
    );

    modport master (
        output m0_addr, m0_wr_req, m0_be, m0_wr_data, m0_rd_req,
        input  m0_wr_ready, m0_rd_ready, m0_rd_data, m0_err,
        output m1_addr, m1_wr_req, m1_be, m1_wr_data, m1_rd_req,
        input  m1_wr_ready, m1_rd_ready, m1_rd_data, m1_err,
        input  s_addr, s_be, s_wr_data, s_wr_req, s_rd_req,
        output s_wr_ready, s_rd_ready, s_rd_data
    );
endinterface

// File: rtl/xrv_dbus_arb.sv
// Two-master arbiter for the core data bus: one outstanding transfer, grant held until the
// slave completes, the master withdraws, or the grant times out with an error completion.
module xrv_dbus_arb #(
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rstb,
    xrv_dbus_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [31:0]   TO_DATA = 32'hDEAD_BEEF;

    state_t          state;
    logic            last_m1;
    logic [TO_W-1:0] to_cnt;

    logic        m0_req, m1_req;
    logic        in_gnt;
    logic        k_wr_req, k_rd_req, k_req;
    logic        done_ok, to_hit;
    logic        cpl_wr, cpl_rd;
    logic [31:0] cpl_data;

    assign m0_req   = bus.m0_wr_req | bus.m0_rd_req;
    assign m1_req   = bus.m1_wr_req | bus.m1_rd_req;
    assign in_gnt   = (state == GNT0) || (state == GNT1);
    assign k_wr_req = (state == GNT1) ? bus.m1_wr_req : bus.m0_wr_req;
    assign k_rd_req = (state == GNT1) ? bus.m1_rd_req : bus.m0_rd_req;
    assign k_req    = k_wr_req | k_rd_req;

    // Slave completions only count for the request type the granted master actually raised.
    assign done_ok  = in_gnt && ((bus.s_wr_ready && k_wr_req) || (bus.s_rd_ready && k_rd_req));
    assign to_hit   = TO_EN && in_gnt && k_req && !done_ok && (to_cnt == TO_LAST);

    assign cpl_wr   = k_wr_req && (bus.s_wr_ready || to_hit);
    assign cpl_rd   = k_rd_req && (bus.s_rd_ready || to_hit);
    assign cpl_data = to_hit ? TO_DATA :
                      (k_rd_req && bus.s_rd_ready) ? bus.s_rd_data : 32'h0;

    always_comb begin
        bus.s_addr      = 32'h0;
        bus.s_be        = 4'h0;
        bus.s_wr_data   = 32'h0;
        bus.s_wr_req    = 1'b0;
        bus.s_rd_req    = 1'b0;
        bus.m0_wr_ready = 1'b0;
        bus.m0_rd_ready = 1'b0;
        bus.m0_rd_data  = 32'h0;
        bus.m0_err      = 1'b0;
        bus.m1_wr_ready = 1'b0;
        bus.m1_rd_ready = 1'b0;
        bus.m1_rd_data  = 32'h0;
        bus.m1_err      = 1'b0;
        case (state)
            GNT0: begin
                bus.s_addr      = bus.m0_addr;
                bus.s_be        = bus.m0_be;
                bus.s_wr_data   = bus.m0_wr_data;
                bus.s_wr_req    = bus.m0_wr_req;
                bus.s_rd_req    = bus.m0_rd_req;
                bus.m0_wr_ready = cpl_wr;
                bus.m0_rd_ready = cpl_rd;
                bus.m0_rd_data  = cpl_data;
                bus.m0_err      = to_hit;
            end
            GNT1: begin
                bus.s_addr      = bus.m1_addr;
                bus.s_be        = bus.m1_be;
                bus.s_wr_data   = bus.m1_wr_data;
                bus.s_wr_req    = bus.m1_wr_req;
                bus.s_rd_req    = bus.m1_rd_req;
                bus.m1_wr_ready = cpl_wr;
                bus.m1_rd_ready = cpl_rd;
                bus.m1_rd_data  = cpl_data;
                bus.m1_err      = to_hit;
            end
            default: ;
        endcase
    end

    // last_m1 resets high so M0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
            to_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (m0_req && (!m1_req || !RR_EN || last_m1)) begin
                        state <= GNT0;
                    end else if (m1_req) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (!k_req || done_ok || to_hit) begin
                        state   <= IDLE;
                        last_m1 <= (state == GNT1);
                        to_cnt  <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xrv_dbus_arb.sv
// Directed bench for xrv_dbus_arb: one round-robin instance with a short timeout and one
// fixed-priority instance, driven by hand-written cycle sequences.
module tb_xrv_dbus_arb;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    xrv_dbus_arb_if ia ();
    xrv_dbus_arb_if ib ();

    xrv_dbus_arb #(.RR_EN(1'b1), .TIMEOUT(4), .TO_W(8)) u_dut_rr (
        .clk  (clk),
        .rstb (rstb),
        .bus  (ia)
    );

    xrv_dbus_arb #(.RR_EN(1'b0), .TIMEOUT(255), .TO_W(8)) u_dut_fp (
        .clk  (clk),
        .rstb (rstb),
        .bus  (ib)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        ia.m0_addr = '0; ia.m0_wr_req = 0; ia.m0_be = '0; ia.m0_wr_data = '0; ia.m0_rd_req = 0;
        ia.m1_addr = '0; ia.m1_wr_req = 0; ia.m1_be = '0; ia.m1_wr_data = '0; ia.m1_rd_req = 0;
        ia.s_wr_ready = 0; ia.s_rd_ready = 0; ia.s_rd_data = '0;
        ib.m0_addr = '0; ib.m0_wr_req = 0; ib.m0_be = '0; ib.m0_wr_data = '0; ib.m0_rd_req = 0;
        ib.m1_addr = '0; ib.m1_wr_req = 0; ib.m1_be = '0; ib.m1_wr_data = '0; ib.m1_rd_req = 0;
        ib.s_wr_ready = 0; ib.s_rd_ready = 0; ib.s_rd_data = '0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        idle_inputs();
        repeat (2) nxt();
        rstb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rstb = 1'b0;
        nxt(); settle();
        check("rst_s_rd_req", ia.s_rd_req, 0);
        check("rst_s_wr_req", ia.s_wr_req, 0);
        check("rst_s_addr", ia.s_addr, 0);
        check("rst_m0_rd_data", ia.m0_rd_data, 0);
        check("rst_m1_err", ia.m1_err, 0);
        nxt();
        rstb = 1'b1;

        // M0 read, slave answers two cycles after s_rd_req
        ia.m0_addr = 32'h100; ia.m0_rd_req = 1; settle();
        check("t1_arb_latency", ia.s_rd_req, 0);
        nxt(); settle();
        check("t1_s_rd_req", ia.s_rd_req, 1);
        check("t1_s_addr", ia.s_addr, 32'h100);
        nxt(); settle();
        check("t1_wait_ready", ia.m0_rd_ready, 0);
        nxt(); ia.s_rd_ready = 1; ia.s_rd_data = 32'h12345678; settle();
        check("t1_m0_rd_ready", ia.m0_rd_ready, 1);
        check("t1_m0_rd_data", ia.m0_rd_data, 32'h12345678);
        check("t1_m0_err", ia.m0_err, 0);
        check("t1_m1_rd_ready", ia.m1_rd_ready, 0);
        check("t1_m1_rd_data", ia.m1_rd_data, 0);
        nxt(); ia.s_rd_ready = 0; ia.s_rd_data = 0; ia.m0_rd_req = 0; settle();
        check("t1_idle_s_rd_req", ia.s_rd_req, 0);
        check("t1_idle_m0_rd_ready", ia.m0_rd_ready, 0);
        check("t1_idle_m0_rd_data", ia.m0_rd_data, 0);

        // Round-robin ties
        do_reset();
        ia.m0_addr = 32'h200; ia.m0_rd_req = 1;
        ia.m1_addr = 32'h300; ia.m1_wr_req = 1; ia.m1_wr_data = 32'hA5A5A5A5; ia.m1_be = 4'hC;
        settle();
        check("t2_idle_s_wr_req", ia.s_wr_req, 0);
        check("t2_idle_s_rd_req", ia.s_rd_req, 0);
        nxt(); ia.s_rd_ready = 1; ia.s_rd_data = 32'h11; settle();
        check("t2_tie1_m0_addr", ia.s_addr, 32'h200);
        check("t2_tie1_s_wr_req", ia.s_wr_req, 0);
        check("t2_tie1_m0_rd_ready", ia.m0_rd_ready, 1);
        check("t2_tie1_m1_wr_ready", ia.m1_wr_ready, 0);
        nxt(); ia.m0_rd_req = 0; ia.s_rd_ready = 0; settle();
        check("t2_gap_s_wr_req", ia.s_wr_req, 0);
        nxt(); ia.s_wr_ready = 1; settle();
        check("t2_m1_addr", ia.s_addr, 32'h300);
        check("t2_m1_wr_data", ia.s_wr_data, 32'hA5A5A5A5);
        check("t2_m1_be", ia.s_be, 32'hC);
        check("t2_m1_s_wr_req", ia.s_wr_req, 1);
        check("t2_m1_wr_ready", ia.m1_wr_ready, 1);
        check("t2_m1_err", ia.m1_err, 0);
        nxt(); ia.m1_wr_req = 0; ia.s_wr_ready = 0;
        ia.m0_rd_req = 1;
        nxt(); ia.s_rd_ready = 1; settle();
        check("t2_m0_alone_ready", ia.m0_rd_ready, 1);
        nxt(); ia.m0_rd_req = 0; ia.s_rd_ready = 0;
        nxt(); ia.m0_rd_req = 1; ia.m1_wr_req = 1;
        nxt(); ia.s_wr_ready = 1; settle();
        check("t2_tie2_m1_first", ia.s_addr, 32'h300);
        check("t2_tie2_m1_wr_ready", ia.m1_wr_ready, 1);
        check("t2_tie2_m0_rd_ready", ia.m0_rd_ready, 0);
        nxt(); ia.m1_wr_req = 0; ia.s_wr_ready = 0;
        nxt(); ia.s_rd_ready = 1; settle();
        check("t2_tie2_m0_second", ia.s_addr, 32'h200);
        check("t2_tie2_m0_rd_ready", ia.m0_rd_ready, 1);
        nxt(); ia.m0_rd_req = 0; ia.s_rd_ready = 0;

        // M1 write in progress stalls an M0 read
        nxt(); ia.m1_addr = 32'h400; ia.m1_wr_req = 1;
        nxt(); ia.m0_addr = 32'h500; ia.m0_rd_req = 1; settle();
        check("t3_gnt1_addr_c1", ia.s_addr, 32'h400);
        check("t3_gnt1_s_wr_req", ia.s_wr_req, 1);
        nxt(); settle();
        check("t3_gnt1_addr_c2", ia.s_addr, 32'h400);
        check("t3_gnt1_s_rd_req", ia.s_rd_req, 0);
        check("t3_m0_stalled", ia.m0_rd_ready, 0);
        nxt(); ia.s_wr_ready = 1; settle();
        check("t3_gnt1_addr_c3", ia.s_addr, 32'h400);
        check("t3_m1_wr_ready", ia.m1_wr_ready, 1);
        check("t3_m0_no_ready", ia.m0_rd_ready, 0);
        nxt(); ia.s_wr_ready = 0; ia.m1_wr_req = 0; settle();
        check("t3_gap_s_rd_req", ia.s_rd_req, 0);
        nxt(); settle();
        check("t3_m0_granted_addr", ia.s_addr, 32'h500);
        check("t3_m0_granted_req", ia.s_rd_req, 1);
        check("t4_to_c1", ia.m0_rd_ready, 0);

        // Timeout: slave never answers the M0 read
        for (int c = 2; c <= 3; c++) begin
            nxt(); settle();
            check("t4_to_wait", ia.m0_rd_ready, 0);
            check("t4_to_err_wait", ia.m0_err, 0);
        end
        nxt(); settle();
        check("t4_to_rd_ready", ia.m0_rd_ready, 1);
        check("t4_to_err", ia.m0_err, 1);
        check("t4_to_rd_data", ia.m0_rd_data, 32'hDEADBEEF);
        check("t4_to_wr_ready", ia.m0_wr_ready, 0);
        check("t4_to_s_rd_req_held", ia.s_rd_req, 1);
        nxt(); ia.m0_rd_req = 0; settle();
        check("t4_after_s_rd_req", ia.s_rd_req, 0);
        check("t4_after_err", ia.m0_err, 0);

        // Reset in the middle of an M0 read, then a late/spurious slave completion
        nxt(); ia.m0_addr = 32'h600; ia.m0_rd_req = 1;
        nxt(); settle();
        check("t5_pre_rst_s_rd_req", ia.s_rd_req, 1);
        #1 rstb = 1'b0;
        #1;
        check("t5_async_s_rd_req", ia.s_rd_req, 0);
        check("t5_async_s_addr", ia.s_addr, 0);
        nxt(); rstb = 1'b1; ia.m0_rd_req = 0;
        ia.s_rd_ready = 1; ia.s_wr_ready = 1; ia.s_rd_data = 32'h55; settle();
        check("t5_no_m0_rd_ready", ia.m0_rd_ready, 0);
        check("t5_no_m0_rd_data", ia.m0_rd_data, 0);
        check("t5_no_m1_wr_ready", ia.m1_wr_ready, 0);
        check("t5_no_m0_err", ia.m0_err, 0);
        nxt(); ia.s_rd_ready = 0; ia.s_wr_ready = 0; ia.s_rd_data = 0; settle();
        check("t5_still_idle", ia.s_rd_req, 0);

        // Fixed priority instance
        ib.m0_addr = 32'hA0; ib.m1_addr = 32'hB0; ib.m0_rd_req = 1; ib.m1_rd_req = 1;
        nxt(); ib.s_rd_ready = 1; settle();
        check("t6_tie1_m0", ib.s_addr, 32'hA0);
        check("t6_tie1_m0_ready", ib.m0_rd_ready, 1);
        check("t6_tie1_m1_ready", ib.m1_rd_ready, 0);
        nxt(); ib.m0_rd_req = 0; ib.s_rd_ready = 0;
        nxt(); ib.s_rd_ready = 1; settle();
        check("t6_m1_after", ib.s_addr, 32'hB0);
        check("t6_m1_ready", ib.m1_rd_ready, 1);
        nxt(); ib.m1_rd_req = 0; ib.s_rd_ready = 0;
        nxt(); ib.m0_rd_req = 1;
        nxt(); ib.s_rd_ready = 1; settle();
        check("t6_m0_alone_ready", ib.m0_rd_ready, 1);
        nxt(); ib.m0_rd_req = 0; ib.s_rd_ready = 0;
        nxt(); ib.m0_rd_req = 1; ib.m1_rd_req = 1;
        nxt(); ib.s_rd_ready = 1; settle();
        check("t6_fixed_m0_again", ib.s_addr, 32'hA0);
        check("t6_fixed_m1_waits", ib.m1_rd_ready, 0);
        nxt(); ib.m0_rd_req = 0; ib.s_rd_ready = 0;
        nxt(); ib.s_rd_ready = 1; settle();
        check("t6_m1_last", ib.s_addr, 32'hB0);
        nxt(); ib.m1_rd_req = 0; ib.s_rd_ready = 0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
